mux_arb_stream: RTL and testbench
=================================

Name: mux_arb_stream

Overview:
- Parametrised successor to the fixed 8-way 16-bit combinational mux.
- Selects one of N W-bit input channels and forwards the word through a registered output stage, using per-channel valid/ready handshakes.
- Two modes: round-robin arbitration among requesting channels, or fixed selection by a select input.
- Sits between multiple producers (register file read ports, memory-mapped sources) and a single consumer on the Hack datapath.

Parameters:
- WIDTH, 16, data width of each channel and of the output.
- N, 8, number of input channels; N >= 2.
- SELW, $clog2(N), width of sel and out_chan; derived, never overridden.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N  channel i has a word pending.
- in_ready  output  N  channel i's word is accepted this cycle.
- mode  input  1  0 = round-robin; 1 = fixed select.
- sel  input  SELW  channel index used when mode = 1.
- out_data  output  WIDTH  registered selected word.
- out_valid  output  1  out_data holds an untransferred word.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_chan  output  SELW  index of the channel that produced out_data.

Behaviour:
- Reset (asynchronous, rst_n low):
  - out_valid = 0, out_data = 0, out_chan = 0.
  - RR pointer last_grant = N-1, so channel 0 has highest priority first.
  - All outputs hold these values while rst_n is low.
  - Reset asserted mid-transfer discards the buffered word with no side effects.
- load_en = !out_valid || out_ready. The output stage is a single-entry pipeline register: it reloads in the same cycle it is drained, so full throughput is 1 word/cycle.
- Grant (combinational, computed every cycle):
  - mode = 1: grant_valid = in_valid[sel] && (sel < N); grant = sel.
  - mode = 0: grant = first index i with in_valid[i] set, scanning last_grant+1, last_grant+2, ... and wrapping modulo N. grant_valid = |in_valid.
- in_ready[i] = load_en && grant_valid && (grant == i). At most one bit is set. in_ready is never asserted while the stage is full and out_ready = 0.
- On a rising edge with load_en && grant_valid:
  - out_data <= the granted channel's word.
  - out_chan <= grant.
  - out_valid <= 1.
  - If mode = 0: last_grant <= grant.
- On a rising edge with load_en && !grant_valid: out_valid <= 0; out_data and out_chan hold their values.
- On a rising edge with !load_en: all state holds (backpressure). Input words stay pending and producers must hold in_data/in_valid.
- Latency: 1 cycle from the in_valid/in_ready transfer to out_valid.
- Fixed mode does not update last_grant. Returning to round-robin resumes from the last RR grant.
- Mode or sel changes take effect at the next arbitration. A word already buffered is unaffected.
- Fairness in RR mode: with all N channels valid continuously and out_ready = 1, grants cycle 0, 1, ..., N-1, 0, ... with no repeats.
- N not a power of 2: sel >= N gives no grant in fixed mode. The RR scan never produces an index >= N.

Decomposition:
- Shared package mux_arb_pkg holds the mode encodings MODE_RR = 1'b0 and MODE_FIXED = 1'b1, plus a clog2 helper if the toolchain lacks $clog2.
- One natural sub-module: rr_arbiter (parameter N). Inputs: req[N], last_grant, enable. Outputs: grant index, grant_valid. It is purely combinational; last_grant is owned by the top-level register. Reusable by future multi-port memory arbitration.

Test Plan:
- Reset, then only channel 3 valid with in_data[3] = 16'hDDDD, mode = 0, out_ready = 1 -> in_ready = 8'b0000_1000 at cycle 0; out_valid = 1, out_data = 16'hDDDD, out_chan = 3 the next cycle.
- All 8 channels valid with a..h = AAAA, BBBB, CCCC, DDDD, EEEE, FFFF, 1234, 5678, mode = 0, out_ready = 1 for 10 cycles -> out_chan sequence 0,1,2,3,4,5,6,7,0,1; out_data sequence AAAA, BBBB, ..., 5678, AAAA, BBBB.
- mode = 1, sel stepped 000..111 every 2 cycles, all channels valid -> out_data follows the selected channel with 1-cycle latency (AAAA .. 5678); only in_ready[sel] is set.
- Backpressure: stage full with AAAA, out_ready = 0 for 3 cycles -> in_ready = 0, out_data stays AAAA and out_valid stays 1; on out_ready = 1, BBBB loads the same cycle AAAA drains.
- mode = 1, sel = 5, in_valid[5] = 0, others valid -> in_ready = 0, out_valid falls to 0 after the drain; switch to mode = 0 -> arbitration resumes from the saved last_grant.
- Assert rst_n = 0 asynchronously mid-stream with out_valid = 1 -> out_valid = 0 and out_data = 0 immediately, without waiting for a clock edge; after release, channel 0 wins first.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared definitions for the stream mux/arbiter: mode encodings.
package mux_arb_pkg;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

endpackage

// File: rtl/mux_arb_stream_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester after last_grant, wrapping modulo N.
module rr_arbiter #(
  parameter  int N    = 8,
  localparam int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] last_grant,
  input  logic            enable,
  output logic [SELW-1:0] grant,
  output logic            grant_valid
);

  // Scan offsets from farthest to nearest so the nearest requester is the final assignment.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    for (int k = N; k >= 1; k--) begin
      int idx;
      idx = (int'(last_grant) + k) % N;
      if (enable && req[idx]) begin
        grant       = SELW'(idx);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_arb_stream.sv
// N-way W-bit stream mux with round-robin or fixed selection and a single registered output stage.
module mux_arb_stream
  import mux_arb_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int N     = 8,
  localparam int SELW  = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_chan
);

  logic [WIDTH-1:0] data_q, data_d;
  logic [SELW-1:0]  chan_q, chan_d;
  logic             valid_q, valid_d;
  logic [SELW-1:0]  last_grant_q, last_grant_d;

  logic [WIDTH-1:0] chan_data [N];
  logic             load_en;
  logic [SELW-1:0]  rr_grant, grant;
  logic             rr_valid, fixed_valid, grant_valid;
  logic             sel_in_range;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_chan
      assign chan_data[gi] = in_data[gi*WIDTH +: WIDTH];
      assign in_ready[gi]  = load_en && grant_valid && (grant == SELW'(gi));
    end
  endgenerate

  // The stage reloads in the same cycle it drains, giving one word per cycle.
  assign load_en = !valid_q || out_ready;

  rr_arbiter #(.N(N)) u_rr (
    .req         (in_valid),
    .last_grant  (last_grant_q),
    .enable      (mode == MODE_RR),
    .grant       (rr_grant),
    .grant_valid (rr_valid)
  );

  // Guards non-power-of-two N, where sel can name a channel that does not exist.
  assign sel_in_range = int'(sel) < N;
  assign fixed_valid  = sel_in_range && in_valid[sel];

  assign grant       = (mode == MODE_FIXED) ? sel : rr_grant;
  assign grant_valid = (mode == MODE_FIXED) ? fixed_valid : rr_valid;

  always_comb begin
    data_d       = data_q;
    chan_d       = chan_q;
    valid_d      = valid_q;
    last_grant_d = last_grant_q;
    if (load_en) begin
      if (grant_valid) begin
        data_d  = chan_data[grant];
        chan_d  = grant;
        valid_d = 1'b1;
        if (mode == MODE_RR) last_grant_d = grant;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q       <= '0;
      chan_q       <= '0;
      valid_q      <= 1'b0;
      last_grant_q <= SELW'(N - 1);
    end else begin
      data_q       <= data_d;
      chan_q       <= chan_d;
      valid_q      <= valid_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_data  = data_q;
  assign out_chan  = chan_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_mux_arb_stream.sv
// Self-checking bench for mux_arb_stream: spec-level model checked every cycle plus directed literal checks.
module tb_mux_arb_stream;

  localparam int WIDTH = 16;
  localparam int N     = 8;

  logic               clk;
  logic               rst_n;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic               mode;
  logic [2:0]         sel;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic [2:0]         out_chan;

  int errors = 0;
  int checks = 0;

  logic [15:0] tbl [8] = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD,
                           16'hEEEE, 16'hFFFF, 16'h1234, 16'h5678};

  mux_arb_stream #(.WIDTH(WIDTH), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_chan  (out_chan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        m_valid = 1'b0;
  logic [15:0] m_data  = '0;
  logic [2:0]  m_chan  = '0;
  int          m_last  = N - 1;

  // Returns the channel that must be granted, or -1 when none.
  function automatic int exp_grant(logic [N-1:0] v, logic md, logic [2:0] s, int last);
    if (md) return (int'(s) < N && v[s]) ? int'(s) : -1;
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (last + k) % N;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    int g;
    logic load;
    load = !m_valid || out_ready;
    g = exp_grant(in_valid, mode, sel, m_last);
    if (load && g >= 0) return N'(1) << g;
    return '0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_chan  <= '0;
      m_last  <= N - 1;
    end else if (!m_valid || out_ready) begin
      int g;
      g = exp_grant(in_valid, mode, sel, m_last);
      if (g >= 0) begin
        m_valid <= 1'b1;
        m_data  <= in_data[g*WIDTH +: WIDTH];
        m_chan  <= 3'(g);
        if (!mode) m_last <= g;
      end else begin
        m_valid <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk("model_out_valid", 32'(out_valid), 32'(m_valid));
    chk("model_out_data",  32'(out_data),  32'(m_data));
    chk("model_out_chan",  32'(out_chan),  32'(m_chan));
    chk("model_in_ready",  32'(in_ready),  32'(exp_ready()));
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_table();
    for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = tbl[i];
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_data = '0; in_valid = '0; mode = 1'b0; sel = '0; out_ready = 1'b0;
    #1;
    do_reset();
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data",  32'(out_data),  32'd0);
    chk("reset_out_chan",  32'(out_chan),  32'd0);

    // Single requester on channel 3.
    in_data[3*WIDTH +: WIDTH] = 16'hDDDD;
    in_valid = 8'b0000_1000; out_ready = 1'b1;
    #1;
    chk("ch3_in_ready", 32'(in_ready), 32'h08);
    step();
    chk("ch3_out_valid", 32'(out_valid), 32'd1);
    chk("ch3_out_data",  32'(out_data),  32'hDDDD);
    chk("ch3_out_chan",  32'(out_chan),  32'd3);
    in_valid = '0;
    step();
    chk("idle_out_valid", 32'(out_valid), 32'd0);

    // Round-robin fairness from a fresh reset.
    do_reset();
    load_table();
    in_valid = '1; mode = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      chk($sformatf("rr_chan_%0d", c), 32'(out_chan), 32'(c % N));
      chk($sformatf("rr_data_%0d", c), 32'(out_data), 32'(tbl[c % N]));
    end

    // Fixed select sweep.
    mode = 1'b1;
    for (int s = 0; s < N; s++) begin
      sel = 3'(s);
      #1;
      chk($sformatf("fix_ready_%0d", s), 32'(in_ready), 32'(8'd1 << s));
      step();
      chk($sformatf("fix_data_%0d", s), 32'(out_data), 32'(tbl[s]));
      step();
    end

    // Backpressure holds the buffered word.
    sel = 3'd0;
    step();
    chk("bp_load", 32'(out_data), 32'hAAAA);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      step();
      chk("bp_out_data",  32'(out_data),  32'hAAAA);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
    end
    sel = 3'd1; out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'h02);
    step();
    chk("bp_release_data", 32'(out_data), 32'hBBBB);

    // Fixed select on an idle channel, then resume round-robin after last RR grant (1).
    sel = 3'd5; in_valid = 8'b1101_1111;
    #1;
    chk("idle_sel_ready", 32'(in_ready), 32'd0);
    step();
    chk("idle_sel_valid", 32'(out_valid), 32'd0);
    mode = 1'b0;
    #1;
    chk("resume_ready", 32'(in_ready), 32'h04);
    step();
    chk("resume_chan", 32'(out_chan), 32'd2);
    chk("resume_data", 32'(out_data), 32'hCCCC);

    // Asynchronous reset mid-stream.
    in_valid = '1;
    step();
    step();
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", 32'(out_valid), 32'd0);
    chk("async_out_data",  32'(out_data),  32'd0);
    chk("async_out_chan",  32'(out_chan),  32'd0);
    #2;
    rst_n = 1'b1;
    step();
    chk("post_reset_chan", 32'(out_chan), 32'd0);
    chk("post_reset_data", 32'(out_data), 32'hAAAA);
    step();
    chk("post_reset_chan2", 32'(out_chan), 32'd1);

    in_valid = '0;
    step();
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
